// File: rtl/onchip_mem_arbiter.sv
// Two-master round-robin controller for a single-port on-chip RAM
// (1-cycle read latency). Read returns are steered back to their owner
// with a one-deep-per-cycle tag pipeline. A fill sequencer can overwrite
// every word with a constant, taking the RAM away from both masters while
// it runs.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int BE_W  = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    // requester 0 (CPU data master)
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    // requester 1 (loader / DMA)
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    // fill sequencer
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    // RAM s1 side
    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    typedef enum logic {
        ST_IDLE,
        ST_FILL
    } state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   fill_cnt_reg;
    logic [DATA_W-1:0]   fill_val_reg;
    logic                fill_busy_reg;
    logic                fill_done_reg;
    logic                last_grant_reg;   // 0 = m0 won last, 1 = m1 won last
    logic                tag_valid_reg;
    logic                tag_owner_reg;

    logic [1:0] rd_in;
    logic [1:0] wr_in;
    logic [1:0] req;
    logic [1:0] rd_only;
    logic [1:0] grant;
    logic [1:0] wait_vec;
    logic [1:0] rdv_vec;

    assign rd_in = {m1_read, m0_read};
    assign wr_in = {m1_write, m0_write};

    // Per-requester request decode, stall and return strobe. A simultaneous
    // read+write is a write, so it never produces a read return.
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign req[gi]      = rd_in[gi] | wr_in[gi];
        assign rd_only[gi]  = rd_in[gi] & ~wr_in[gi];
        assign wait_vec[gi] = req[gi] & ~grant[gi];
        assign rdv_vec[gi]  = tag_valid_reg & (tag_owner_reg == 1'(gi));
    end

    assign m0_waitrequest   = wait_vec[0];
    assign m1_waitrequest   = wait_vec[1];
    assign m0_readdatavalid = rdv_vec[0];
    assign m1_readdatavalid = rdv_vec[1];
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign mem_clken        = 1'b1;
    assign fill_busy        = fill_busy_reg;
    assign fill_done        = fill_done_reg;

    // Round-robin grant, only while the fill sequencer is idle; on contention
    // the master that did not win last time gets the slot.
    always_comb begin
        grant = 2'b00;
        if (state_reg == ST_IDLE) begin
            if (req[0] && (!req[1] || last_grant_reg)) begin
                grant[0] = 1'b1;
            end else if (req[1]) begin
                grant[1] = 1'b1;
            end
        end
    end

    // RAM port mux: fill sequencer has priority, otherwise the granted master.
    always_comb begin
        mem_address    = '0;
        mem_byteenable = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        if (state_reg == ST_FILL) begin
            mem_address    = fill_cnt_reg;
            mem_byteenable = '1;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_writedata  = fill_val_reg;
        end else if (grant[0]) begin
            mem_address    = m0_address;
            mem_byteenable = m0_byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m0_write;
            mem_writedata  = m0_writedata;
        end else if (grant[1]) begin
            mem_address    = m1_address;
            mem_byteenable = m1_byteenable;
            mem_chipselect = 1'b1;
            mem_write      = m1_write;
            mem_writedata  = m1_writedata;
        end
    end

    // Arbitration history and read-return tag; the tag lines up with the
    // RAM's one-cycle read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg <= 1'b1;
            tag_valid_reg  <= 1'b0;
            tag_owner_reg  <= 1'b0;
        end else begin
            if (grant[0]) begin
                last_grant_reg <= 1'b0;
            end else if (grant[1]) begin
                last_grant_reg <= 1'b1;
            end
            tag_valid_reg <= (grant[0] & rd_only[0]) | (grant[1] & rd_only[1]);
            tag_owner_reg <= grant[1];
        end
    end

    // Fill FSM: sweeps every address once, then pulses fill_done for one
    // cycle. A start request during a sweep is ignored.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ST_IDLE;
            fill_cnt_reg  <= '0;
            fill_val_reg  <= '0;
            fill_busy_reg <= 1'b0;
            fill_done_reg <= 1'b0;
        end else begin
            fill_done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (fill_start) begin
                        state_reg     <= ST_FILL;
                        fill_cnt_reg  <= '0;
                        fill_val_reg  <= fill_value;
                        fill_busy_reg <= 1'b1;
                    end
                end
                ST_FILL: begin
                    fill_cnt_reg <= fill_cnt_reg + 1'b1;
                    if (fill_cnt_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg     <= ST_IDLE;
                        fill_busy_reg <= 1'b0;
                        fill_done_reg <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    fill_busy_reg <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Directed bench for onchip_mem_arbiter: a table of single-cycle vectors for
// arbitration, byte lanes and read steering, then hand sequences for the
// fill sweep, an ignored restart, and reset in the middle of a fill.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [9:0]  m0_address = '0, m1_address = '0;
    logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
    logic        m0_read = 1'b0, m0_write = 1'b0, m1_read = 1'b0, m1_write = 1'b0;
    logic [31:0] m0_writedata = '0, m1_writedata = '0;
    logic        m0_waitrequest, m1_waitrequest;
    logic [31:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic        fill_start = 1'b0;
    logic [31:0] fill_value = '0;
    logic        fill_busy, fill_done;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write, mem_clken;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(10), .DATA_W(32), .DEPTH(1024)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .fill_start(fill_start), .fill_value(fill_value), .fill_busy(fill_busy),
        .fill_done(fill_done),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    // Single-port RAM model, unregistered output, one-cycle read latency.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
                end
            end
            mem_readdata <= ram[mem_address];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        m0_rd, m0_wr;
        logic [9:0]  m0_addr;
        logic [3:0]  m0_be;
        logic [31:0] m0_wd;
        logic        m1_rd, m1_wr;
        logic [9:0]  m1_addr;
        logic [3:0]  m1_be;
        logic [31:0] m1_wd;
        logic        e_w0, e_w1, e_cs, e_we;
        logic [9:0]  e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic        e_rdv0, e_rdv1;
        logic [31:0] e_rdata;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs [NVEC];

    task automatic drive_m0(input logic rd, input logic wr, input logic [9:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = wd;
    endtask

    task automatic drive_m1(input logic rd, input logic wr, input logic [9:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = wd;
    endtask

    initial begin
        int bad_cycles;
        int done_seen;

        //            m0: rd wr addr be wd                     m1: rd wr addr be wd                     exp: w0 w1 cs we addr be wd                        rdv0 rdv1 rdata
        vecs[0]  = '{1'b0,1'b1,10'h005,4'hF,32'h12345678, 1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b1,1'b1,10'h005,4'hF,32'h12345678, 1'b0,1'b0,32'h0};
        vecs[1]  = '{1'b1,1'b0,10'h005,4'hF,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b1,1'b0,10'h005,4'hF,32'h0,        1'b0,1'b0,32'h0};
        vecs[2]  = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,4'h0,32'h0,        1'b1,1'b0,32'h12345678};
        vecs[3]  = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b1,10'h020,4'hF,32'h0,        1'b0,1'b0,1'b1,1'b1,10'h020,4'hF,32'h0,        1'b0,1'b0,32'h0};
        vecs[4]  = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b1,10'h020,4'h3,32'hAABBCCDD, 1'b0,1'b0,1'b1,1'b1,10'h020,4'h3,32'hAABBCCDD, 1'b0,1'b0,32'h0};
        vecs[5]  = '{1'b0,1'b1,10'h010,4'hF,32'h11110000, 1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b1,1'b1,10'h010,4'hF,32'h11110000, 1'b0,1'b0,32'h0};
        vecs[6]  = '{1'b1,1'b0,10'h010,4'hF,32'h0,        1'b1,1'b0,10'h020,4'hF,32'h0,        1'b1,1'b0,1'b1,1'b0,10'h020,4'hF,32'h0,        1'b0,1'b0,32'h0};
        vecs[7]  = '{1'b1,1'b0,10'h010,4'hF,32'h0,        1'b1,1'b0,10'h020,4'hF,32'h0,        1'b0,1'b1,1'b1,1'b0,10'h010,4'hF,32'h0,        1'b0,1'b1,32'h0000CCDD};
        vecs[8]  = '{1'b1,1'b0,10'h010,4'hF,32'h0,        1'b1,1'b0,10'h020,4'hF,32'h0,        1'b1,1'b0,1'b1,1'b0,10'h020,4'hF,32'h0,        1'b1,1'b0,32'h11110000};
        vecs[9]  = '{1'b1,1'b0,10'h010,4'hF,32'h0,        1'b1,1'b0,10'h020,4'hF,32'h0,        1'b0,1'b1,1'b1,1'b0,10'h010,4'hF,32'h0,        1'b0,1'b1,32'h0000CCDD};
        vecs[10] = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,4'h0,32'h0,        1'b1,1'b0,32'h11110000};
        vecs[11] = '{1'b1,1'b1,10'h030,4'hF,32'h00000055, 1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b1,1'b1,10'h030,4'hF,32'h00000055, 1'b0,1'b0,32'h0};
        vecs[12] = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,32'h0};
        vecs[13] = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b1,1'b0,10'h030,4'hF,32'h0,        1'b0,1'b0,1'b1,1'b0,10'h030,4'hF,32'h0,        1'b0,1'b0,32'h0};
        vecs[14] = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b1,32'h00000055};
        vecs[15] = '{1'b0,1'b1,10'h040,4'hF,32'hA5A5A5A5, 1'b1,1'b0,10'h030,4'hF,32'h0,        1'b0,1'b1,1'b1,1'b1,10'h040,4'hF,32'hA5A5A5A5, 1'b0,1'b0,32'h0};
        vecs[16] = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b1,1'b0,10'h030,4'hF,32'h0,        1'b0,1'b0,1'b1,1'b0,10'h030,4'hF,32'h0,        1'b0,1'b0,32'h0};
        vecs[17] = '{1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b0,1'b0,1'b0,10'h000,4'h0,32'h0,        1'b0,1'b1,32'h00000055};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wait0", 32'(m0_waitrequest), 32'd0);
        chk("rst_wait1", 32'(m1_waitrequest), 32'd0);
        chk("rst_rdv", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
        chk("rst_fill", {30'd0, fill_busy, fill_done}, 32'd0);
        chk("rst_cs", {30'd0, mem_chipselect, mem_write}, 32'd0);
        chk("rst_clken", 32'(mem_clken), 32'd1);
        reset_n = 1'b1;

        // ---- table-driven vectors ----
        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk); #1;
            drive_m0(vecs[i].m0_rd, vecs[i].m0_wr, vecs[i].m0_addr, vecs[i].m0_be, vecs[i].m0_wd);
            drive_m1(vecs[i].m1_rd, vecs[i].m1_wr, vecs[i].m1_addr, vecs[i].m1_be, vecs[i].m1_wd);
            @(negedge clk);
            $display("vec %0d: wait=%b%b cs=%b we=%b addr=%h rdv=%b%b rdata=%h", i,
                     m1_waitrequest, m0_waitrequest, mem_chipselect, mem_write, mem_address,
                     m1_readdatavalid, m0_readdatavalid, m0_readdata);
            chk($sformatf("v%0d_wait0", i), 32'(m0_waitrequest), 32'(vecs[i].e_w0));
            chk($sformatf("v%0d_wait1", i), 32'(m1_waitrequest), 32'(vecs[i].e_w1));
            chk($sformatf("v%0d_cs", i), 32'(mem_chipselect), 32'(vecs[i].e_cs));
            chk($sformatf("v%0d_we", i), 32'(mem_write), 32'(vecs[i].e_we));
            if (vecs[i].e_cs) begin
                chk($sformatf("v%0d_addr", i), 32'(mem_address), 32'(vecs[i].e_addr));
                chk($sformatf("v%0d_be", i), 32'(mem_byteenable), 32'(vecs[i].e_be));
            end
            if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), mem_writedata, vecs[i].e_wd);
            chk($sformatf("v%0d_rdv0", i), 32'(m0_readdatavalid), 32'(vecs[i].e_rdv0));
            chk($sformatf("v%0d_rdv1", i), 32'(m1_readdatavalid), 32'(vecs[i].e_rdv1));
            if (vecs[i].e_rdv0) chk($sformatf("v%0d_rdata0", i), m0_readdata, vecs[i].e_rdata);
            if (vecs[i].e_rdv1) chk($sformatf("v%0d_rdata1", i), m1_readdata, vecs[i].e_rdata);
        end

        // ---- fill sweep with a read accepted in the start cycle ----
        @(posedge clk); #1;
        fill_start = 1'b1; fill_value = 32'hDEADBEEF;
        drive_m0(1'b1, 1'b0, 10'h005, 4'hF, 32'h0);
        drive_m1(1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        @(negedge clk);
        chk("fs_start_wait0", 32'(m0_waitrequest), 32'd0);
        chk("fs_start_busy", 32'(fill_busy), 32'd0);
        bad_cycles = 0;
        done_seen = 0;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk); #1;
            // cycle 500: a second start pulse with a different value must be ignored
            fill_start = (i == 500);
            fill_value = (i == 500) ? 32'h01234567 : 32'hDEADBEEF;
            drive_m0(1'b1, 1'b0, 10'h000, 4'hF, 32'h0);
            @(negedge clk);
            if (i == 0) begin
                chk("fs_first_rdv0", 32'(m0_readdatavalid), 32'd1);
                chk("fs_first_rdata", m0_readdata, 32'h12345678);
            end
            if (fill_done) done_seen++;
            if (!fill_busy || !m0_waitrequest || !mem_chipselect || !mem_write ||
                mem_byteenable != 4'hF || mem_address != 10'(i) || mem_writedata != 32'hDEADBEEF)
                bad_cycles++;
        end
        fill_start = 1'b0;
        $display("fill 0xDEADBEEF: 1024 cycles, bad_cycles=%0d early_done=%0d", bad_cycles, done_seen);
        chk("fs_sweep_bad_cycles", 32'(bad_cycles), 32'd0);
        chk("fs_no_early_done", 32'(done_seen), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("fs_done_pulse", 32'(fill_done), 32'd1);
        chk("fs_busy_clear", 32'(fill_busy), 32'd0);
        chk("fs_resume_wait0", 32'(m0_waitrequest), 32'd0);
        chk("fs_resume_rd", {30'd0, mem_chipselect, mem_write}, 32'd2);
        @(posedge clk); #1;
        drive_m0(1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
        @(negedge clk);
        chk("fs_done_once", 32'(fill_done), 32'd0);
        chk("fs_rd0_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("fs_rd0_data", m0_readdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive_m0(1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        @(negedge clk);
        $display("fill readback @3FF: rdv=%b data=%h", m0_readdatavalid, m0_readdata);
        chk("fs_rd3ff_rdv", 32'(m0_readdatavalid), 32'd1);
        chk("fs_rd3ff_data", m0_readdata, 32'hDEADBEEF);

        // ---- reset in the middle of a fill ----
        @(posedge clk); #1;
        fill_start = 1'b1; fill_value = 32'hCAFEF00D;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1;
            fill_start = 1'b0;
        end
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("rm_busy_now", 32'(fill_busy), 32'd0);
        chk("rm_done_now", 32'(fill_done), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fill_done || fill_busy) done_seen++;
        end
        $display("reset mid-fill: stray busy/done cycles=%0d", done_seen);
        chk("rm_no_done", 32'(done_seen), 32'd0);
        @(posedge clk); #1;
        drive_m0(1'b1, 1'b0, 10'h3FF, 4'hF, 32'h0);
        drive_m1(1'b1, 1'b0, 10'h000, 4'hF, 32'h0);
        @(negedge clk);
        chk("rm_cont_wait0", 32'(m0_waitrequest), 32'd0);
        chk("rm_cont_wait1", 32'(m1_waitrequest), 32'd1);
        chk("rm_cont_addr", 32'(mem_address), 32'h3FF);
        @(posedge clk); #1;
        drive_m0(1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        @(negedge clk);
        chk("rm_m1_wait1", 32'(m1_waitrequest), 32'd0);
        chk("rm_rdv0", 32'(m0_readdatavalid), 32'd1);
        chk("rm_3ff_kept", m0_readdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        drive_m1(1'b0, 1'b0, 10'h000, 4'h0, 32'h0);
        @(negedge clk);
        $display("reset mid-fill readback @000: rdv1=%b data=%h", m1_readdatavalid, m1_readdata);
        chk("rm_rdv1", 32'(m1_readdatavalid), 32'd1);
        chk("rm_000_partial", m1_readdata, 32'hCAFEF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-requester controller for the single-port 1024x32 on-chip RAM (altsyncram, SINGLE_PORT, unregistered output, 1-cycle read latency).
- Round-robin arbitration of two Avalon-MM masters (CPU data master, loader/DMA) onto the RAM s1 signals.
- Tags read returns to their owner.
- Contains a fill sequencer that initialises the whole RAM to a constant.

Parameters:
ADDR_W, 10, word address width
DATA_W, 32, data width; byteenable width BE_W = DATA_W/8
DEPTH, 1024, number of words; fill covers addresses 0..DEPTH-1

Ports:
clk  in  1  single clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  ADDR_W  requester 0 word address
m0_byteenable  in  BE_W  requester 0 byte lanes
m0_read  in  1  requester 0 read request
m0_write  in  1  requester 0 write request
m0_writedata  in  DATA_W  requester 0 write data
m0_waitrequest  out  1  requester 0 stall
m0_readdata  out  DATA_W  requester 0 read data
m0_readdatavalid  out  1  requester 0 read return strobe
m1_*  same set as m0_*, for requester 1
fill_start  in  1  pulse: start RAM fill
fill_value  in  DATA_W  fill word, sampled on fill_start
fill_busy  out  1  fill in progress
fill_done  out  1  one-cycle pulse at fill completion
mem_address  out  ADDR_W  to RAM address
mem_byteenable  out  BE_W  to RAM byteenable
mem_chipselect  out  1  to RAM chipselect
mem_write  out  1  to RAM write
mem_writedata  out  DATA_W  to RAM writedata
mem_clken  out  1  to RAM clken; constant 1
mem_readdata  in  DATA_W  from RAM readdata

Behaviour:
Reset (async assert, sync release):
- state=IDLE; fill counter=0; last_grant=1, so m0 wins the first contention.
- Read tags cleared; fill_busy=0; fill_done=0; m*_readdatavalid=0.
- m*_waitrequest follows its combinational rule (0 with no request).
- Reset mid-fill aborts the fill; no fill_done pulse.

Request and arbitration:
- req_i = mi_read | mi_write.
- If mi_read and mi_write are both asserted, treat it as a write; no readdatavalid is returned.
- IDLE arbitration is combinational each cycle:
  - Only one requester active: it is granted.
  - Both active: grant the one not equal to last_grant.
  - last_grant updates on every accepted transfer.
- mi_waitrequest = req_i & ~grant_i; outside IDLE, mi_waitrequest = req_i.
- Accepted transfer drives the RAM:
  - mem_chipselect=1, mem_write=write, plus address, byteenable and writedata of the winner.
  - With no grant, mem_chipselect=0 and mem_write=0.
- Write: completes in the accept cycle.

Read returns:
- Accepted read sets a registered tag: valid plus owner.
- In the next cycle, m<owner>_readdatavalid=1; the other master's readdatavalid=0.
- Both m*_readdata = mem_readdata, qualified by readdatavalid.
- Reads are fully pipelined: one accepted per cycle, returned in order.

Fill FSM (states IDLE, FILL):
- IDLE→FILL on fill_start. Requests in that same cycle are still arbitrated normally.
- On fill_start, latch fill_value and clear the counter.
- In FILL, every cycle:
  - mem_chipselect=1, mem_write=1, mem_byteenable=all ones.
  - mem_address=counter, mem_writedata=latched value; counter increments.
- fill_busy=1 throughout FILL.
- A read accepted in the cycle before FILL still returns its readdatavalid in the first FILL cycle.
- After writing address DEPTH-1:
  - FILL→IDLE.
  - fill_done=1 in the first IDLE cycle only.
  - Arbitration resumes in that same cycle.
- Fill takes exactly DEPTH cycles.
- fill_start during FILL is ignored; the counter does not restart.

Test Plan:
1. m0 write 0x12345678 @0x005 (byteenable=F), then m0 read @0x005 -> readdatavalid on m0 one cycle after the read is accepted, readdata=0x12345678; m1_readdatavalid stays 0.
2. m0 and m1 both read continuously from reset, at 0x010 and 0x020 -> grants alternate m0,m1,m0,m1; each master's waitrequest=1 on alternate cycles; readdatavalid returns to the correct owner each cycle.
3. m1 write 0xAABBCCDD, byteenable=0x3, onto a word holding 0 -> subsequent read returns 0x0000CCDD.
4. fill_start with fill_value=0xDEADBEEF -> fill_busy=1 for 1024 cycles; requests held with waitrequest=1; fill_done pulses once; reads @0x000 and @0x3FF return 0xDEADBEEF.
5. Second fill_start pulse at fill cycle 500 -> ignored; fill_done exactly 1024 cycles after the first start.
6. reset_n low at fill cycle 300, then high -> fill_busy=0 immediately; no fill_done; m0 wins the first contention after release.
